// File: rtl/npu_label_select.sv
// npu_label_select: turns the per-inference NPU class-score stream into a
// frame-stable 4-bit label selector for the overlay.
// An argmax with a confidence threshold, a PERSIST-deep debounce, frame-start
// gated commit, and a stall timeout that blanks the label.
module npu_label_select #(
    parameter int NUM_CLASSES    = 12,
    parameter int SCORE_W        = 16,
    parameter int THRESHOLD      = 0,
    parameter int PERSIST        = 3,
    parameter int TIMEOUT_FRAMES = 60,
    parameter bit VS_POL         = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      vs_i,
    input  logic                      score_valid_i,
    output logic                      score_ready_o,
    input  logic signed [SCORE_W-1:0] score_data_i,
    input  logic                      score_last_i,
    output logic [3:0]                text_option_o,
    output logic [3:0]                cand_code_o,
    output logic                      infer_err_o
);

    localparam int CNT_W = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_W-1:0]          LAST_IDX  = CNT_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]          NUM_CNT   = CNT_W'(NUM_CLASSES);
    localparam logic signed [SCORE_W-1:0] THRESH_S  = SCORE_W'(THRESHOLD);
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [3:0]                PERSIST_C = 4'(PERSIST);
    localparam logic [7:0]                TIMEOUT_C = 8'(TIMEOUT_FRAMES);

    typedef enum logic {
        ACCUM  = 1'b0,
        DECIDE = 1'b1
    } state_t;

    state_t                      state_q;
    logic                        ready_q;
    logic [CNT_W-1:0]            beat_cnt_q;
    logic signed [SCORE_W-1:0]   best_score_q;
    logic [3:0]                  best_code_q;
    logic                        drop_q;
    logic                        err_q;

    logic                        vs_q, vs_q2;
    logic [3:0]                  cand_q, cand_d;
    logic [3:0]                  persist_q, persist_d;
    logic [3:0]                  pending_q, pending_d;
    logic [7:0]                  frames_q, frames_d;
    logic [3:0]                  text_q, text_d;

    logic                        beat_acc;
    logic                        frame_start;
    logic                        is_decide;
    logic [3:0]                  decision;
    logic [7:0]                  frames_inc;

    assign beat_acc    = score_valid_i && ready_q;
    assign frame_start = (vs_q == VS_POL) && (vs_q2 != VS_POL);
    assign is_decide   = (state_q == DECIDE);

    // Inference accumulator FSM: argmax tracking, framing checks, discard of malformed bursts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ACCUM;
            ready_q      <= 1'b0;
            beat_cnt_q   <= '0;
            best_score_q <= SCORE_MIN;
            best_code_q  <= '0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (beat_acc) begin
                        if (drop_q) begin
                            // Tail of a discarded burst: swallow beats until its last.
                            if (score_last_i) begin
                                drop_q <= 1'b0;
                            end
                        end else if (score_last_i && (beat_cnt_q == LAST_IDX)) begin
                            if (score_data_i > best_score_q) begin
                                best_score_q <= score_data_i;
                                best_code_q  <= 4'(beat_cnt_q) + 4'd1;
                            end
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                            state_q    <= DECIDE;
                            ready_q    <= 1'b0;
                        end else if (score_last_i || (beat_cnt_q >= NUM_CNT)) begin
                            err_q        <= 1'b1;
                            beat_cnt_q   <= '0;
                            best_score_q <= SCORE_MIN;
                            best_code_q  <= '0;
                            drop_q       <= !score_last_i;
                        end else begin
                            if (score_data_i > best_score_q) begin
                                best_score_q <= score_data_i;
                                best_code_q  <= 4'(beat_cnt_q) + 4'd1;
                            end
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    beat_cnt_q   <= '0;
                    best_score_q <= SCORE_MIN;
                    best_code_q  <= '0;
                    state_q      <= ACCUM;
                    ready_q      <= 1'b1;
                end
                default: begin
                    state_q <= ACCUM;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Debounce, commit and frame-start update; a DECIDE in the same cycle as a
    // frame start is folded in first so the new code lands on that very frame.
    always_comb begin
        decision   = (best_score_q > THRESH_S) ? best_code_q : 4'd0;
        frames_inc = (frames_q == 8'hFF) ? 8'hFF : frames_q + 8'd1;
        cand_d     = cand_q;
        persist_d  = persist_q;
        pending_d  = pending_q;
        frames_d   = frames_q;
        text_d     = text_q;
        if (is_decide) begin
            if (decision == cand_q) begin
                persist_d = (persist_q >= PERSIST_C) ? PERSIST_C : persist_q + 4'd1;
            end else begin
                cand_d    = decision;
                persist_d = 4'd1;
            end
            if (persist_d == PERSIST_C) begin
                pending_d = cand_d;
            end
        end
        if (frame_start) begin
            frames_d = frames_inc;
            text_d   = pending_d;
            // A fresh decision this cycle proves the NPU is alive, so no blanking.
            if (!is_decide && (frames_inc >= TIMEOUT_C)) begin
                pending_d = 4'd0;
                text_d    = 4'd0;
                cand_d    = 4'd0;
                persist_d = 4'd0;
            end
        end
        if (is_decide) begin
            frames_d = 8'd0;
        end
    end

    // Selector state registers and the vs edge-detect pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q      <= 1'b0;
            vs_q2     <= 1'b0;
            cand_q    <= '0;
            persist_q <= '0;
            pending_q <= '0;
            frames_q  <= '0;
            text_q    <= '0;
        end else begin
            vs_q      <= vs_i;
            vs_q2     <= vs_q;
            cand_q    <= cand_d;
            persist_q <= persist_d;
            pending_q <= pending_d;
            frames_q  <= frames_d;
            text_q    <= text_d;
        end
    end

    assign score_ready_o = ready_q;
    assign text_option_o = text_q;
    assign cand_code_o   = cand_q;
    assign infer_err_o   = err_q;

endmodule

// File: tb/tb_npu_label_select.sv
// Testbench for npu_label_select: table of inference+frame vectors, a queue of
// expected labels per frame, and hand sequences for framing errors, timeout,
// DECIDE/frame-start coincidence and mid-inference reset.
module tb_npu_label_select;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               vs_i = 1'b0;
    logic               score_valid_i = 1'b0;
    logic               score_ready_o;
    logic signed [15:0] score_data_i = '0;
    logic               score_last_i = 1'b0;
    logic [3:0]         text_option_o;
    logic [3:0]         cand_code_o;
    logic               infer_err_o;

    npu_label_select dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .vs_i          (vs_i),
        .score_valid_i (score_valid_i),
        .score_ready_o (score_ready_o),
        .score_data_i  (score_data_i),
        .score_last_i  (score_last_i),
        .text_option_o (text_option_o),
        .cand_code_o   (cand_code_o),
        .infer_err_o   (infer_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    int beat_scores [16];
    logic [3:0] exp_q [$];

    always @(negedge clk_i) begin
        if (infer_err_o === 1'b1) err_pulses <= err_pulses + 1;
    end

    typedef struct {
        string      name;
        int         a_code;
        int         a_score;
        int         b_code;
        int         b_score;
        int         base;
        logic [3:0] exp_cand;
        logic [3:0] exp_text;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_scores(input int a_code, input int a_score,
                               input int b_code, input int b_score, input int base);
        for (int k = 0; k < 16; k++) begin
            beat_scores[k] = base;
            if (k + 1 == a_code) beat_scores[k] = a_score;
            if (k + 1 == b_code) beat_scores[k] = b_score;
        end
    endtask

    // last_at==0 means no beat carries score_last.
    task automatic send_beats(input int n, input int last_at, input bit vs_on_last);
        for (int k = 1; k <= n; k++) begin
            int waited;
            waited = 0;
            @(negedge clk_i);
            while (!score_ready_o && waited < 50) begin
                @(negedge clk_i);
                waited++;
            end
            if (!score_ready_o) begin
                n_checks++;
                n_errors++;
                $display("FAIL ready_wait: score_ready stuck at 0, expected 1 within 50 cycles");
            end
            score_valid_i = 1'b1;
            score_data_i  = 16'(beat_scores[k-1]);
            score_last_i  = (k == last_at);
            if (vs_on_last && k == last_at) vs_i = 1'b1;
            @(posedge clk_i);
            #1;
            score_valid_i = 1'b0;
            score_last_i  = 1'b0;
        end
    endtask

    task automatic send_inf(input int a_code, input int a_score,
                            input int b_code, input int b_score, input int base);
        fill_scores(a_code, a_score, b_code, b_score, base);
        send_beats(12, 12, 1'b0);
    endtask

    // One vs pulse; expected label queued when driven, compared once the frame has started.
    task automatic vs_frame(input string name, input logic [3:0] exp);
        logic [3:0] e;
        exp_q.push_back(exp);
        @(negedge clk_i);
        vs_i = 1'b1;
        repeat (4) @(negedge clk_i);
        vs_i = 1'b0;
        repeat (4) @(negedge clk_i);
        e = exp_q.pop_front();
        check(name, int'(text_option_o), int'(e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int ep;

        tbl[0]  = '{"t1_inf1", 4, 500, 0, 0, 10, 4'd4, 4'd0};
        tbl[1]  = '{"t1_inf2", 4, 500, 0, 0, 10, 4'd4, 4'd0};
        tbl[2]  = '{"t1_inf3", 4, 500, 0, 0, 10, 4'd4, 4'd4};
        tbl[3]  = '{"t2_inf1", 0, 0, 0, 0, -5, 4'd0, 4'd4};
        tbl[4]  = '{"t2_inf2", 0, 0, 0, 0, -5, 4'd0, 4'd4};
        tbl[5]  = '{"t2_inf3", 0, 0, 0, 0, -5, 4'd0, 4'd0};
        tbl[6]  = '{"t3_tie1", 2, 300, 7, 300, 10, 4'd2, 4'd0};
        tbl[7]  = '{"t3_tie2", 2, 300, 7, 300, 10, 4'd2, 4'd0};
        tbl[8]  = '{"t3_tie3", 2, 300, 7, 300, 10, 4'd2, 4'd2};
        tbl[9]  = '{"t4_alt5a", 5, 500, 0, 0, 10, 4'd5, 4'd2};
        tbl[10] = '{"t4_alt6a", 6, 500, 0, 0, 10, 4'd6, 4'd2};
        tbl[11] = '{"t4_alt5b", 5, 500, 0, 0, 10, 4'd5, 4'd2};
        tbl[12] = '{"t4_alt6b", 6, 500, 0, 0, 10, 4'd6, 4'd2};

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_text", int'(text_option_o), 0);
        check("rst_cand", int'(cand_code_o), 0);
        check("rst_err", int'(infer_err_o), 0);
        check("rst_ready", int'(score_ready_o), 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("ready_after_rst", int'(score_ready_o), 1);

        // Table: one inference then one frame each
        for (int i = 0; i < 13; i++) begin
            send_inf(tbl[i].a_code, tbl[i].a_score, tbl[i].b_code, tbl[i].b_score, tbl[i].base);
            vs_frame({tbl[i].name, "_text"}, tbl[i].exp_text);
            check({tbl[i].name, "_cand"}, int'(cand_code_o), int'(tbl[i].exp_cand));
        end
        check("t1_extra_vs_no_err", err_pulses, 0);

        // Malformed inferences: early last, then an over-long burst
        ep = err_pulses;
        fill_scores(1, 30000, 0, 0, 10);
        send_beats(5, 5, 1'b0);
        fill_scores(13, 30000, 14, 30000, 10);
        send_beats(14, 14, 1'b0);
        repeat (3) @(negedge clk_i);
        check("t5_err_pulses", err_pulses - ep, 2);
        vs_frame("t5_text_unchanged", 4'd2);
        check("t5_cand_unchanged", int'(cand_code_o), 6);
        send_inf(3, 400, 0, 0, 10);
        repeat (2) @(negedge clk_i);
        check("t5_accum_cleared", int'(cand_code_o), 3);
        check("t5_no_extra_err", err_pulses - ep, 2);

        // Commit 9, then stall for 60 frames
        send_inf(9, 700, 0, 0, 10);
        send_inf(9, 700, 0, 0, 10);
        send_inf(9, 700, 0, 0, 10);
        for (int f = 1; f <= 60; f++) begin
            vs_frame($sformatf("t6_idle_frame%0d", f), (f < 60) ? 4'd9 : 4'd0);
        end
        check("t6_cand_cleared", int'(cand_code_o), 0);
        vs_frame("t6_idle_frame61", 4'd0);

        // DECIDE coinciding with a frame start
        send_inf(7, 800, 0, 0, 10);
        send_inf(7, 800, 0, 0, 10);
        check("t6b_text_before", int'(text_option_o), 0);
        fill_scores(7, 800, 0, 0, 10);
        send_beats(12, 12, 1'b1);
        repeat (4) @(negedge clk_i);
        vs_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("t6b_coincide_text", int'(text_option_o), 7);
        check("t6b_coincide_cand", int'(cand_code_o), 7);
        vs_frame("t6b_next_frame", 4'd7);

        // Reset in the middle of an inference
        ep = err_pulses;
        fill_scores(2, 900, 0, 0, 10);
        send_beats(4, 0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("midrst_text", int'(text_option_o), 0);
        check("midrst_cand", int'(cand_code_o), 0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("midrst_no_err", err_pulses - ep, 0);
        check("midrst_text_known", int'($isunknown(text_option_o)), 0);
        send_inf(11, 600, 0, 0, 10);
        repeat (2) @(negedge clk_i);
        check("midrst_new_inf_cand", int'(cand_code_o), 11);
        check("midrst_new_inf_no_err", err_pulses - ep, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
